// File: rtl/time_meter_pkg.sv
// ---------------------------------------------------------------------------
// time_meter_pkg
// Shared defaults and channel-state definitions for the time_meter block.
//   N_CH_DEF     : default number of measurement channels
//   CNT_W_DEF    : default result/counter width
//   TICK_DIV_DEF : default clk cycles per time tick (1 ms at 50 MHz)
//   ch_phase_e   : per-cycle classification of a channel from (en, en_q)
// ---------------------------------------------------------------------------
package time_meter_pkg;

    localparam int N_CH_DEF     = 4;
    localparam int CNT_W_DEF    = 19;
    localparam int TICK_DIV_DEF = 50000;

    // What a channel does in the current cycle, derived from the live enable
    // and its registered copy.
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,   // en=0, en_q=0
        CH_START = 2'd1,   // en=1, en_q=0
        CH_RUN   = 2'd2,   // en=1, en_q=1
        CH_STOP  = 2'd3    // en=0, en_q=1
    } ch_phase_e;

    function automatic ch_phase_e ch_classify(input logic en, input logic en_q);
        ch_phase_e phase;
        case ({en, en_q})
            2'b10:   phase = CH_START;
            2'b11:   phase = CH_RUN;
            2'b01:   phase = CH_STOP;
            default: phase = CH_IDLE;
        endcase
        return phase;
    endfunction

endpackage

// File: rtl/time_meter_ch.sv
// ---------------------------------------------------------------------------
// time_meter_ch
// One measurement channel: registers the enable, counts ticks while the
// window is open (saturating), and publishes the result on window close.
// Optional feature: define TIME_METER_MAX_EN to add a running maximum of
// completed results with a per-channel clear.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   tick       : shared time tick from the prescaler
//   en         : measurement window (high = measuring)
//   res        : last completed duration in ticks
//   done       : one-cycle pulse when res/ovf update
//   ovf        : last completed measurement saturated
//   busy       : measurement in progress (registered enable)
//   max_clr    : (TIME_METER_MAX_EN) clear max_res, wins over an update
//   max_res    : (TIME_METER_MAX_EN) largest result since last clear/reset
// ---------------------------------------------------------------------------
module time_meter_ch
    import time_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
`ifdef TIME_METER_MAX_EN
    input  logic             max_clr,
    output logic [CNT_W-1:0] max_res,
`endif
    output logic [CNT_W-1:0] res,
    output logic             done,
    output logic             ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ALL_ONES = {CNT_W{1'b1}};

    logic             en_q,      en_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             run_ovf_q, run_ovf_d;
    logic [CNT_W-1:0] res_q,     res_d;
    logic             ovf_q,     ovf_d;
    logic             done_q,    done_d;
`ifdef TIME_METER_MAX_EN
    logic [CNT_W-1:0] max_q,     max_d;
`endif

    ch_phase_e phase;

    always_comb begin
        phase     = ch_classify(en, en_q);
        en_d      = en;
        cnt_d     = cnt_q;
        run_ovf_d = run_ovf_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
`ifdef TIME_METER_MAX_EN
        max_d     = max_q;
`endif
        case (phase)
            CH_START: begin
                // A tick coinciding with the opening cycle is deliberately
                // not counted: only cycles with en=1 and en_q=1 count.
                cnt_d     = '0;
                run_ovf_d = 1'b0;
            end
            CH_RUN: begin
                if (tick) begin
                    // Saturate rather than wrap; the overflow flag marks
                    // that at least one tick was lost.
                    if (cnt_q == CNT_ALL_ONES) begin
                        run_ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CH_STOP: begin
                res_d  = cnt_q;
                ovf_d  = run_ovf_q;
                done_d = 1'b1;
`ifdef TIME_METER_MAX_EN
                if (cnt_q > max_q) begin
                    max_d = cnt_q;
                end
`endif
            end
            default: begin
            end
        endcase
`ifdef TIME_METER_MAX_EN
        if (max_clr) begin
            max_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            cnt_q     <= '0;
            run_ovf_q <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef TIME_METER_MAX_EN
            max_q     <= '0;
`endif
        end else begin
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            run_ovf_q <= run_ovf_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
`ifdef TIME_METER_MAX_EN
            max_q     <= max_d;
`endif
        end
    end

    assign res  = res_q;
    assign ovf  = ovf_q;
    assign done = done_q;
    assign busy = en_q;
`ifdef TIME_METER_MAX_EN
    assign max_res = max_q;
`endif

endmodule

// File: rtl/time_meter.sv
// ---------------------------------------------------------------------------
// time_meter
// Multi-channel pulse-width meter. A single free-running prescaler produces
// a time tick shared by N_CH independent channels; each channel measures how
// many ticks elapse while its enable is high.
// Optional feature: define TIME_METER_MAX_EN to add max_clr/max_res.
// Ports:
//   clk      : sole clock, rising edge
//   rst      : synchronous active-high reset
//   en       : [N_CH] per-channel measurement window
//   res      : [N_CH*CNT_W] last results, channel i at [i*CNT_W +: CNT_W]
//   done     : [N_CH] one-cycle pulse when a channel's result updates
//   ovf      : [N_CH] last completed measurement saturated
//   busy     : [N_CH] measurement in progress
//   max_clr  : [N_CH] (TIME_METER_MAX_EN) clear running maximum
//   max_res  : [N_CH*CNT_W] (TIME_METER_MAX_EN) running maximum of results
// ---------------------------------------------------------------------------
module time_meter
    import time_meter_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       en,
`ifdef TIME_METER_MAX_EN
    input  logic [N_CH-1:0]       max_clr,
    output logic [N_CH*CNT_W-1:0] max_res,
`endif
    output logic [N_CH*CNT_W-1:0] res,
    output logic [N_CH-1:0]       done,
    output logic [N_CH-1:0]       ovf,
    output logic [N_CH-1:0]       busy
);

    // A one-bit prescaler is kept for TICK_DIV=1 so the width is never zero;
    // it then sits at 0, which is also its terminal value, so tick is always 1.
    localparam int                PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = presc_q + PRESC_W'(1);
        if (tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            time_meter_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .tick    (tick),
                .en      (en[gi]),
`ifdef TIME_METER_MAX_EN
                .max_clr (max_clr[gi]),
                .max_res (max_res[gi*CNT_W +: CNT_W]),
`endif
                .res     (res[gi*CNT_W +: CNT_W]),
                .done    (done[gi]),
                .ovf     (ovf[gi]),
                .busy    (busy[gi])
            );
        end
    endgenerate

endmodule
